disp_stream_unpacker: RTL and testbench

Receiving end of the 9-bit packed disparity stream (`{SOF, disp[7:0]}`) produced by the left-right consistency stage. It strips the SOF flag, tracks pixel/line position, and re-emits the data as an AXI4-Stream video stream (`tuser` = start of frame, `tlast` = end of line) toward the VDMA. The upstream source cannot be stalled, so a small FIFO absorbs downstream backpressure, and overflow or frame-structure faults are flagged rather than propagated.

---
 rtl/disp_stream_pkg.sv | 20 ++
 rtl/disp_sync_fifo.sv | 68 ++++++
 rtl/disp_stream_unpacker.sv | 145 ++++++++++++++
 tb/tb_disp_stream_unpacker.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_stream_pkg.sv
// Shared types and constants for the packed disparity stream unpacker.
// Optional statistics are enabled with DISP_STATS_EN (see disp_stream_unpacker).
package disp_stream_pkg;

  localparam int OUTPUTDATAWID = 9;
  localparam int DISP_WIDTH    = 8;
  localparam int SOF_BIT       = OUTPUTDATAWID - 1;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    STREAM   = 1'b1
  } unpackState_t;

  typedef struct packed {
    logic                  tuser;
    logic                  tlast;
    logic [DISP_WIDTH-1:0] disp;
  } fifoEntry_t;

endpackage

// File: rtl/disp_sync_fifo.sv
// Single-clock FIFO with a registered head: a push into an empty FIFO is visible
// on dout/valid the next cycle. A push on a full FIFO succeeds if a pop frees an entry.
module disp_sync_fifo
  import disp_stream_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  fifoEntry_t din,
  input  logic       pop,
  output fifoEntry_t dout,
  output logic       valid,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);

  fifoEntry_t      mem [DEPTH];
  logic [AW-1:0]   wrPtr;
  logic [AW-1:0]   rdPtr;
  logic [AW:0]     count;
  logic            doPop;
  logic            doPush;
  logic [AW:0]     remain;
  logic [AW:0]     nextCount;
  logic [AW-1:0]   nextRd;

  assign full      = (count == (AW+1)'(DEPTH));
  assign doPop     = pop && valid;
  assign doPush    = push && (!full || doPop);
  assign remain    = count - {{AW{1'b0}}, doPop};
  assign nextCount = remain + {{AW{1'b0}}, doPush};
  assign nextRd    = rdPtr + AW'(doPop);

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= din;
    end
  end

  // The head register is reloaded from the entry that will be at the front next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      valid <= 1'b0;
      dout  <= '0;
    end else begin
      count <= nextCount;
      rdPtr <= nextRd;
      valid <= (nextCount != '0);
      if (doPush) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (remain == '0) begin
        if (doPush) begin
          dout <= din;
        end
      end else begin
        dout <= mem[nextRd];
      end
    end
  end

endmodule

// File: rtl/disp_stream_unpacker.sv
// Unpacks {SOF, disp} words into an AXI4-Stream video stream with frame tracking.
// Define DISP_STATS_EN to add the per-frame zero-disparity counter outputs.
//
// state    | meaning
// WAIT_SOF | discard words until one carries SOF
// STREAM   | inside a frame, every accepted word is a pixel
module disp_stream_unpacker #(
  parameter int OUTPUTDATAWID = 9,
  parameter int DISP_WIDTH    = 8,
  parameter int IMG_WIDTH     = 640,
  parameter int IMG_HEIGHT    = 480,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [OUTPUTDATAWID-1:0] disp_in,
  input  logic                     disp_in_valid,
  output logic [DISP_WIDTH-1:0]    m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tuser,
  output logic                     m_axis_tlast,
  output logic                     frame_err,
`ifdef DISP_STATS_EN
  output logic [19:0]              invalid_count,
  output logic                     stats_valid,
`endif
  output logic                     ovf
);

  import disp_stream_pkg::*;

  localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  unpackState_t           state;
  logic [XW-1:0]          x;
  logic [YW-1:0]          y;
  logic                   sof;
  logic [DISP_WIDTH-1:0]  disp;
  logic                   take;
  logic                   badSof;
  logic                   lastPix;
  logic [XW-1:0]          px;
  logic [YW-1:0]          py;
  fifoEntry_t             entry;
  fifoEntry_t             head;
  logic                   fifoFull;
  logic                   drop;

  assign sof     = disp_in[SOF_BIT];
  assign disp    = disp_in[DISP_WIDTH-1:0];
  assign take    = disp_in_valid && ((state == STREAM) || sof);
  assign badSof  = disp_in_valid && sof && (state == STREAM) && !((x == '0) && (y == '0));
  // An SOF word always lands at the origin, whether it opens or restarts a frame.
  assign px      = sof ? '0 : x;
  assign py      = sof ? '0 : y;
  assign lastPix = (px == X_LAST) && (py == Y_LAST);
  assign drop    = take && fifoFull && !(m_axis_tvalid && m_axis_tready);

  assign entry.tuser = (px == '0) && (py == '0);
  assign entry.tlast = (px == X_LAST);
  assign entry.disp  = disp;

  disp_sync_fifo #(.DEPTH(FIFO_DEPTH)) uFifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (take),
    .din   (entry),
    .pop   (m_axis_tready),
    .dout  (head),
    .valid (m_axis_tvalid),
    .full  (fifoFull)
  );

  assign m_axis_tdata = head.disp;
  assign m_axis_tuser = head.tuser;
  assign m_axis_tlast = head.tlast;

  // Position advances on every accepted word, even if the FIFO drops it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_SOF;
      x         <= '0;
      y         <= '0;
      frame_err <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      frame_err <= badSof;
      if (drop) begin
        ovf <= 1'b1;
      end
      if (take) begin
        if (px == X_LAST) begin
          x <= '0;
          if (py == Y_LAST) begin
            y     <= '0;
            state <= WAIT_SOF;
          end else begin
            y     <= py + YW'(1);
            state <= STREAM;
          end
        end else begin
          x     <= px + XW'(1);
          y     <= py;
          state <= STREAM;
        end
      end
    end
  end

`ifdef DISP_STATS_EN
  logic [19:0] zeroCnt;
  logic        isZero;

  assign isZero = (disp == '0);

  // A premature SOF closes the previous frame and its own pixel starts the new count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zeroCnt       <= '0;
      invalid_count <= '0;
      stats_valid   <= 1'b0;
    end else begin
      stats_valid <= 1'b0;
      if (take) begin
        if (badSof) begin
          invalid_count <= zeroCnt;
          stats_valid   <= 1'b1;
          zeroCnt       <= {19'd0, isZero};
        end else if (lastPix) begin
          invalid_count <= (zeroCnt == '1) ? zeroCnt : zeroCnt + {19'd0, isZero};
          stats_valid   <= 1'b1;
          zeroCnt       <= '0;
        end else if (isZero && (zeroCnt != '1)) begin
          zeroCnt <= zeroCnt + 20'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_disp_stream_unpacker.sv
// Self-checking bench for disp_stream_unpacker on a 4x2 frame with a 16-entry FIFO.
// Works in both builds; DISP_STATS_EN adds the statistics checks.
module tb_disp_stream_unpacker;

  localparam int W = 4;
  localparam int H = 2;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] disp_in;
  logic       disp_in_valid;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       m_axis_tuser;
  logic       m_axis_tlast;
  logic       frame_err;
  logic       ovf;
`ifdef DISP_STATS_EN
  logic [19:0] invalid_count;
  logic        stats_valid;
`endif

  always #5 clk = ~clk;

  disp_stream_unpacker #(
    .OUTPUTDATAWID(9), .DISP_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .disp_in(disp_in), .disp_in_valid(disp_in_valid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast), .frame_err(frame_err),
`ifdef DISP_STATS_EN
    .invalid_count(invalid_count), .stats_valid(stats_valid),
`endif
    .ovf(ovf)
  );

  typedef struct packed {
    logic       tuser;
    logic       tlast;
    logic [7:0] disp;
  } beat_t;

  typedef struct {
    bit         v;
    logic [8:0] w;
    bit         rdy;
    bit         eValid;
    logic [7:0] eData;
    bit         eUser;
    bit         eLast;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // reference model: frame position as a linear pixel index, FIFO as a bounded queue
  beat_t q[$];
  int    pos;
  bit    inFrame;
  bit    ovfExp;
  bit    ferrExp;
  int    zeros;
  bit    statsValidExp;
  int    statsCountExp;
  int    beatsOut;
  int    ferrCount;
  bit    holdPending;
  beat_t holdBeat;
  bit    lastRdy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    q.delete();
    pos = 0;
    inFrame = 0;
    ovfExp = 0;
    ferrExp = 0;
    zeros = 0;
    statsValidExp = 0;
    statsCountExp = 0;
    holdPending = 0;
  endtask

  task automatic modelStep(input bit v, input logic [8:0] w, input bit rdy);
    beat_t b;
    if (q.size() > 0 && rdy) begin
      void'(q.pop_front());
      beatsOut++;
    end
    ferrExp = 0;
    statsValidExp = 0;
    if (v && (inFrame || w[8])) begin
      if (w[8]) begin
        if (inFrame && pos != 0) begin
          ferrExp = 1;
          statsValidExp = 1;
          statsCountExp = zeros;
          zeros = 0;
        end
        pos = 0;
        inFrame = 1;
      end
      b.tuser = (pos == 0);
      b.tlast = ((pos % W) == W - 1);
      b.disp  = w[7:0];
      if (q.size() < DEPTH) q.push_back(b);
      else ovfExp = 1;
      if (w[7:0] == 8'd0) zeros++;
      pos++;
      if (pos == W * H) begin
        pos = 0;
        inFrame = 0;
        statsValidExp = 1;
        statsCountExp = zeros;
        zeros = 0;
      end
    end
  endtask

  task automatic compareAll();
    if (holdPending && !lastRdy) begin
      check("hold_tvalid", m_axis_tvalid, 1);
      check("hold_beat", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, holdBeat);
    end
    check("tvalid", m_axis_tvalid, q.size() != 0);
    if (q.size() != 0) begin
      check("tdata", m_axis_tdata, q[0].disp);
      check("tuser", m_axis_tuser, q[0].tuser);
      check("tlast", m_axis_tlast, q[0].tlast);
    end
    check("frame_err", frame_err, ferrExp);
    check("ovf", ovf, ovfExp);
`ifdef DISP_STATS_EN
    check("stats_valid", stats_valid, statsValidExp);
    if (statsValidExp) check("invalid_count", invalid_count, statsCountExp);
`endif
    if (frame_err) ferrCount++;
    holdPending = m_axis_tvalid;
    holdBeat = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
  endtask

  task automatic tick(input bit v, input logic [8:0] w, input bit rdy);
    disp_in_valid = v;
    disp_in = w;
    m_axis_tready = rdy;
    lastRdy = rdy;
    @(posedge clk);
    modelStep(v, w, rdy);
    @(negedge clk);
    compareAll();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    disp_in_valid = 1'b0;
    disp_in = '0;
    m_axis_tready = 1'b0;
    repeat (2) @(posedge clk);
    modelReset();
    @(negedge clk);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tuser", m_axis_tuser, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
  endtask

  vec_t vecs[12];
  int   base;

  initial begin
    // three non-SOF words are discarded, then a full 4x2 frame streams through
    vecs[0]  = '{1, 9'h0AA, 1, 0, 8'h00, 0, 0};
    vecs[1]  = '{1, 9'h0BB, 1, 0, 8'h00, 0, 0};
    vecs[2]  = '{1, 9'h0CC, 1, 0, 8'h00, 0, 0};
    vecs[3]  = '{1, 9'h110, 1, 1, 8'h10, 1, 0};
    vecs[4]  = '{1, 9'h011, 1, 1, 8'h11, 0, 0};
    vecs[5]  = '{1, 9'h012, 1, 1, 8'h12, 0, 0};
    vecs[6]  = '{1, 9'h013, 1, 1, 8'h13, 0, 1};
    vecs[7]  = '{1, 9'h014, 1, 1, 8'h14, 0, 0};
    vecs[8]  = '{1, 9'h015, 1, 1, 8'h15, 0, 0};
    vecs[9]  = '{1, 9'h016, 1, 1, 8'h16, 0, 0};
    vecs[10] = '{1, 9'h017, 1, 1, 8'h17, 0, 1};
    vecs[11] = '{0, 9'h000, 1, 0, 8'h00, 0, 0};

    beatsOut = 0;
    ferrCount = 0;
    lastRdy = 0;
    doReset();

    for (int i = 0; i < 12; i++) begin
      tick(vecs[i].v, vecs[i].w, vecs[i].rdy);
      check($sformatf("vec%0d_tvalid", i), m_axis_tvalid, vecs[i].eValid);
      if (vecs[i].eValid) begin
        check($sformatf("vec%0d_tdata", i), m_axis_tdata, vecs[i].eData);
        check($sformatf("vec%0d_tuser", i), m_axis_tuser, vecs[i].eUser);
        check($sformatf("vec%0d_tlast", i), m_axis_tlast, vecs[i].eLast);
      end
    end

    // premature SOF at pixel (2,1)
    ferrCount = 0;
    tick(1, 9'h120, 1);
    for (int i = 1; i < 6; i++) tick(1, 9'(8'h20 + i), 1);
    tick(1, 9'h126, 1);
    check("restart_tuser", m_axis_tuser, 1);
    check("restart_tdata", m_axis_tdata, 8'h26);
    check("restart_ferr", frame_err, 1);
    tick(1, 9'h027, 1);
    tick(1, 9'h028, 1);
    tick(1, 9'h029, 1);
    check("restart_tlast", m_axis_tlast, 1);
    check("restart_tlast_data", m_axis_tdata, 8'h29);
    for (int i = 10; i < 14; i++) tick(1, 9'(8'h20 + i), 1);
    repeat (3) tick(0, 9'h000, 1);
    check("ferr_pulses", ferrCount, 1);

    // overflow with tready held low for 20 words; SOF on each frame start
    for (int i = 0; i < 20; i++) begin
      tick(1, {(i % 8) == 0, 8'(8'h40 + i)}, 0);
      check($sformatf("ovf_word%0d", i + 1), ovf, i >= 16);
    end
    base = beatsOut;
    repeat (18) tick(0, 9'h000, 1);
    check("ovf_drained_beats", beatsOut - base, 16);
    for (int i = 0; i < 4; i++) tick(1, 9'(8'h60 + i), 1);
    check("ovf_tlast_after", m_axis_tlast, 1);
    check("ovf_tlast_data", m_axis_tdata, 8'h63);
    repeat (2) tick(0, 9'h000, 1);

`ifdef DISP_STATS_EN
    tick(1, 9'h100, 1);
    tick(1, 9'h000, 1);
    tick(1, 9'h005, 1);
    tick(1, 9'h000, 1);
    tick(1, 9'h007, 1);
    tick(1, 9'h000, 1);
    tick(1, 9'h009, 1);
    tick(1, 9'h000, 1);
    check("stats_pulse", stats_valid, 1);
    check("stats_count5", invalid_count, 5);
    tick(0, 9'h000, 1);
    check("stats_single_pulse", stats_valid, 0);
`endif

    // mid-frame reset flushes the FIFO, clears ovf and aborts the frame
    tick(1, 9'h150, 0);
    tick(1, 9'h051, 0);
    tick(1, 9'h052, 0);
    rst_n = 1'b0;
    #1;
    check("async_rst_tvalid", m_axis_tvalid, 0);
    check("async_rst_ovf", ovf, 0);
    @(posedge clk);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    tick(1, 9'h053, 1);
    check("aborted_frame_tvalid", m_axis_tvalid, 0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit v;
      bit s;
      bit r;
      logic [7:0] d;
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 15) == 0);
      d = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
      r = (i < 1500) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) != 0);
      tick(v, {s, d}, r);
    end
    repeat (20) tick(0, 9'h000, 1);
    check("final_empty", m_axis_tvalid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
